fp_add_controller: RTL and testbench

- Moore/Mealy FSM that sequences the floating-point adder datapath through load, exponent alignment, add/subtract, carry correction, normalization and completion.
- Consumes the datapath's comparator and status flags. Drives every register load, shift and count strobe.
- Provides a start/done handshake to the surrounding system.

---
 rtl/fp_add_controller.sv | 156 +++++++++++++++
 tb/tb_fp_add_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_add_controller.sv
// Control FSM for the floating-point adder datapath.
// Sequences load, alignment, add/sub, carry fix, normalization, completion.
module fp_add_controller #(
   parameter int MANT_W = 24,
   parameter int ITER_W = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic eq_exp,
   input  logic lt_exp,
   input  logic gt_exp,
   input  logic lt_man,
   input  logic signA_xor_signB,
   input  logic co_sum,
   input  logic most_sig_man_R,
   input  logic or_man_R,
   output logic ld_s_A,
   output logic ld_exp_A,
   output logic ld_man_A,
   output logic ld_s_B,
   output logic ld_exp_B,
   output logic ld_man_B,
   output logic shift_man_right_A,
   output logic count_en_up_A,
   output logic shift_man_right_B,
   output logic count_en_up_B,
   output logic samesign,
   output logic sel_sign_R,
   output logic ld_s_R,
   output logic ld_exp_R,
   output logic ld_man_R,
   output logic shift_man_right_R,
   output logic count_en_up_R,
   output logic shift_man_left_R,
   output logic count_en_down_R,
   output logic ready,
   output logic done,
   output logic zero_R
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] ALIGN = 3'd2;
   localparam logic [2:0] ADD   = 3'd3;
   localparam logic [2:0] CARRY = 3'd4;
   localparam logic [2:0] NORM  = 3'd5;
   localparam logic [2:0] DONE  = 3'd6;

   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MANT_W - 1);

   logic [2:0]        state_q;
   logic [2:0]        state_d;
   logic [ITER_W-1:0] iter_q;
   logic              zero_q;
   logic              ld_ops;
   logic              add_mag;

   assign ld_s_A   = ld_ops;
   assign ld_exp_A = ld_ops;
   assign ld_man_A = ld_ops;
   assign ld_s_B   = ld_ops;
   assign ld_exp_B = ld_ops;
   assign ld_man_B = ld_ops;

   assign add_mag = ~signA_xor_signB;

   // Next-state decode and per-state strobe generation.
   always_comb begin
      state_d           = state_q;
      ld_ops            = 1'b0;
      shift_man_right_A = 1'b0;
      count_en_up_A     = 1'b0;
      shift_man_right_B = 1'b0;
      count_en_up_B     = 1'b0;
      samesign          = 1'b0;
      sel_sign_R        = 1'b0;
      ld_s_R            = 1'b0;
      ld_exp_R          = 1'b0;
      ld_man_R          = 1'b0;
      shift_man_right_R = 1'b0;
      count_en_up_R     = 1'b0;
      shift_man_left_R  = 1'b0;
      count_en_down_R   = 1'b0;
      ready             = 1'b0;
      done              = 1'b0;
      zero_R            = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) state_d = LOAD;
         end
         LOAD: begin
            ld_ops  = 1'b1;
            state_d = ALIGN;
         end
         ALIGN: begin
            if (eq_exp) begin
               state_d = ADD;
            end else if (lt_exp) begin
               shift_man_right_A = 1'b1;
               count_en_up_A     = 1'b1;
            end else if (gt_exp) begin
               shift_man_right_B = 1'b1;
               count_en_up_B     = 1'b1;
            end
         end
         ADD: begin
            samesign   = add_mag;
            sel_sign_R = ~add_mag & lt_man;
            ld_s_R     = 1'b1;
            ld_exp_R   = 1'b1;
            ld_man_R   = 1'b1;
            state_d    = (add_mag & co_sum) ? CARRY : NORM;
         end
         CARRY: begin
            shift_man_right_R = 1'b1;
            count_en_up_R     = 1'b1;
            state_d           = NORM;
         end
         NORM: begin
            if (!or_man_R || most_sig_man_R || iter_q == ITER_LAST) begin
               state_d = DONE;
            end else begin
               shift_man_left_R = 1'b1;
               count_en_down_R  = 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            zero_R  = zero_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, normalization counter and zero-result flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ADD) begin
            iter_q <= '0;
            zero_q <= 1'b0;
         end else if (state_q == NORM) begin
            zero_q <= ~or_man_R;
            if (shift_man_left_R) iter_q <= iter_q + ITER_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fp_add_controller.sv
// Directed bench for fp_add_controller with a tiny reactive datapath model.
// Model tracks exponent difference and leading zeros from the DUT strobes.
module tb_fp_add_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic eq_exp = 1'b0, lt_exp = 1'b0, gt_exp = 1'b0;
   logic lt_man = 1'b0, signA_xor_signB = 1'b0, co_sum = 1'b0;
   logic most_sig_man_R = 1'b0, or_man_R = 1'b0;
   logic ld_s_A, ld_exp_A, ld_man_A, ld_s_B, ld_exp_B, ld_man_B;
   logic shift_man_right_A, count_en_up_A;
   logic shift_man_right_B, count_en_up_B;
   logic samesign, sel_sign_R, ld_s_R, ld_exp_R, ld_man_R;
   logic shift_man_right_R, count_en_up_R;
   logic shift_man_left_R, count_en_down_R;
   logic ready, done, zero_R;
   logic [20:0] all_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp_add_controller #(.MANT_W(24), .ITER_W(5)) dut (
      .clk(clk), .rst(rst), .start(start),
      .eq_exp(eq_exp), .lt_exp(lt_exp), .gt_exp(gt_exp),
      .lt_man(lt_man), .signA_xor_signB(signA_xor_signB),
      .co_sum(co_sum), .most_sig_man_R(most_sig_man_R),
      .or_man_R(or_man_R),
      .ld_s_A(ld_s_A), .ld_exp_A(ld_exp_A), .ld_man_A(ld_man_A),
      .ld_s_B(ld_s_B), .ld_exp_B(ld_exp_B), .ld_man_B(ld_man_B),
      .shift_man_right_A(shift_man_right_A),
      .count_en_up_A(count_en_up_A),
      .shift_man_right_B(shift_man_right_B),
      .count_en_up_B(count_en_up_B),
      .samesign(samesign), .sel_sign_R(sel_sign_R),
      .ld_s_R(ld_s_R), .ld_exp_R(ld_exp_R), .ld_man_R(ld_man_R),
      .shift_man_right_R(shift_man_right_R),
      .count_en_up_R(count_en_up_R),
      .shift_man_left_R(shift_man_left_R),
      .count_en_down_R(count_en_down_R),
      .ready(ready), .done(done), .zero_R(zero_R)
   );

   assign all_out = {ld_s_A, ld_exp_A, ld_man_A, ld_s_B, ld_exp_B,
                     ld_man_B, shift_man_right_A, count_en_up_A,
                     shift_man_right_B, count_en_up_B, samesign,
                     sel_sign_R, ld_s_R, ld_exp_R, ld_man_R,
                     shift_man_right_R, count_en_up_R,
                     shift_man_left_R, count_en_down_R, done, zero_R};

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic drive_flags(input int ediff, input int lz,
                              input bit sx, input bit ltm,
                              input bit co, input bit zr);
      eq_exp          = (ediff == 0);
      lt_exp          = (ediff < 0);
      gt_exp          = (ediff > 0);
      signA_xor_signB = sx;
      lt_man          = ltm;
      co_sum          = co;
      or_man_R        = !zr;
      most_sig_man_R  = !zr && (lz <= 0);
   endtask

   task automatic run_op(input string tag, input int ea, input int eb,
                         input bit sx, input bit ltm, input bit co,
                         input int lz0, input bit zr,
                         input int x_cyc, input int x_a, input int x_b,
                         input int x_c, input int x_l, input bit x_z,
                         input bit x_ss, input bit x_sel);
      int ediff, lz, cyc, na, nb, nc, nl, nld, grp, viol;
      int dcyc, ss, sel, z;
      bit seen;
      ediff = ea - eb; lz = lz0;
      na = 0; nb = 0; nc = 0; nl = 0; nld = 0; viol = 0;
      dcyc = -1; ss = -1; sel = -1; z = -1; seen = 0;
      @(negedge clk);
      drive_flags(ediff, lz, sx, ltm, co, zr);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 400 && !seen) begin
         drive_flags(ediff, lz, sx, ltm, co, zr);
         #1;
         grp = int'(ld_man_A) + int'(shift_man_right_A)
             + int'(shift_man_right_B) + int'(ld_man_R)
             + int'(shift_man_right_R) + int'(shift_man_left_R)
             + int'(done);
         if (grp > 1) viol++;
         if (shift_man_right_A != count_en_up_A) viol++;
         if (shift_man_right_B != count_en_up_B) viol++;
         if (shift_man_right_R != count_en_up_R) viol++;
         if (shift_man_left_R != count_en_down_R) viol++;
         if (ld_man_A) nld++;
         if (shift_man_right_A) begin na++; ediff++; end
         if (shift_man_right_B) begin nb++; ediff--; end
         if (shift_man_right_R) nc++;
         if (shift_man_left_R) begin nl++; lz--; end
         if (ld_man_R) begin ss = samesign; sel = sel_sign_R; end
         if (done) begin
            seen = 1; dcyc = cyc; z = zero_R;
            check({tag, "_ready_in_done"}, ready, 0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, "_timeout"}, seen, 1);
      check({tag, "_done_cycle"}, dcyc, x_cyc);
      check({tag, "_loads"}, nld, 1);
      check({tag, "_shift_A"}, na, x_a);
      check({tag, "_shift_B"}, nb, x_b);
      check({tag, "_carry"}, nc, x_c);
      check({tag, "_left"}, nl, x_l);
      check({tag, "_zero_R"}, z, x_z);
      check({tag, "_samesign"}, ss, x_ss);
      check({tag, "_sel_sign_R"}, sel, x_sel);
      check({tag, "_exclusive"}, viol, 0);
      @(negedge clk);
      #1;
      check({tag, "_back_idle"}, {ready, all_out}, {1'b1, 21'd0});
   endtask

   initial begin
      #3;
      check("reset_ready", ready, 1);
      check("reset_outs", all_out, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("idle_ready", ready, 1);

      // tag ea eb sx ltm co lz zr | cyc a b c l z ss sel
      run_op("one_plus_one", 127, 127, 0, 0, 1, 0, 0,
             6, 0, 0, 1, 0, 0, 1, 0);
      run_op("one_plus_qtr", 127, 125, 0, 0, 0, 0, 0,
             7, 0, 2, 0, 0, 0, 1, 0);
      run_op("one_minus_one", 127, 127, 1, 0, 0, 0, 1,
             5, 0, 0, 0, 0, 1, 0, 0);
      run_op("one_minus_3q", 127, 126, 1, 0, 0, 2, 0,
             8, 0, 1, 0, 2, 0, 0, 0);
      run_op("half_minus_one", 126, 127, 1, 1, 0, 1, 0,
             7, 1, 0, 0, 1, 0, 0, 1);
      run_op("norm_guard", 100, 100, 1, 0, 0, 40, 0,
             28, 0, 0, 0, 23, 0, 0, 0);
      run_op("big_align", 127, 0, 0, 0, 0, 0, 0,
             132, 0, 127, 0, 0, 0, 1, 0);

      // reset during a 10-cycle alignment, with an ignored start
      @(negedge clk);
      drive_flags(10, 0, 0, 0, 0, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("rst_seq_load", ld_man_A, 1);
      @(negedge clk);
      #1;
      check("rst_seq_align", shift_man_right_B, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("rst_seq_no_reload", ld_man_A, 0);
      check("rst_seq_still_align", shift_man_right_B, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_ready", ready, 1);
      check("rst_mid_outs", all_out, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_after_idle", {ready, all_out}, {1'b1, 21'd0});

      run_op("after_reset", 127, 127, 0, 0, 1, 0, 0,
             6, 0, 0, 1, 0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
